// File: rtl/dual_queue_rr_arbiter_if.sv
// ============================================================================
// Module      : dual_queue_rr_arbiter_if
// Description : Producer/consumer bundle for the dual-queue round-robin arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface dual_queue_rr_arbiter_if #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1)
);
  logic [D_WIDTH-1:0] up_data_a;
  logic               push_a;
  logic               full_a;
  logic               overflow_a;
  logic [CW-1:0]      count_a;
  logic [D_WIDTH-1:0] up_data_b;
  logic               push_b;
  logic               full_b;
  logic               overflow_b;
  logic [CW-1:0]      count_b;
  logic [D_WIDTH-1:0] down_data;
  logic               down_src;
  logic               down_valid;
  logic               down_ready;

  modport master (
    output up_data_a, push_a, up_data_b, push_b, down_ready,
    input  full_a, overflow_a, count_a, full_b, overflow_b, count_b,
           down_data, down_src, down_valid
  );

  modport slave (
    input  up_data_a, push_a, up_data_b, push_b, down_ready,
    output full_a, overflow_a, count_a, full_b, overflow_b, count_b,
           down_data, down_src, down_valid
  );
endinterface

`default_nettype wire

// File: rtl/dual_queue_rr_arbiter.sv
// ============================================================================
// Module      : dual_queue_rr_arbiter
// Description : Two DEPTH-entry FIFOs drained round-robin into one registered
//               valid/ready output stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module dual_queue_rr_arbiter #(
  parameter int D_WIDTH = 6,
  parameter int DEPTH   = 4,
  parameter int CW      = $clog2(DEPTH + 1)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  dual_queue_rr_arbiter_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_last_grant;
  logic [D_WIDTH-1:0] r_down_data;
  logic               r_down_src;

  logic [1:0]         w_push;
  logic [1:0]         w_pop;
  logic [1:0]         w_full;
  logic [1:0]         w_ovf;
  logic [1:0]         w_non_empty;
  logic [D_WIDTH-1:0] w_up_data [2];
  logic [D_WIDTH-1:0] w_head    [2];
  logic [CW-1:0]      w_count   [2];
  logic               w_load_en;
  logic               w_grant;

  assign w_push       = {bus.push_b, bus.push_a};
  assign w_up_data[0] = bus.up_data_a;
  assign w_up_data[1] = bus.up_data_b;

  for (genvar q = 0; q < 2; q++) begin : g_queue
    logic [D_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_full;
    logic               r_ovf;
    logic               w_push_ok;
    logic [CW-1:0]      w_count_nxt;

    // Full is judged before the edge, so a same-cycle pop cannot rescue a push.
    assign w_push_ok = w_push[q] & ~r_full;

    always_comb begin
      w_count_nxt = r_count;
      if (w_push_ok && !w_pop[q]) begin
        w_count_nxt = r_count + CW'(1);
      end else if (!w_push_ok && w_pop[q]) begin
        w_count_nxt = r_count - CW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_up_data[q];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_pop[q]) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == CW'(DEPTH));
        if (w_push[q] && r_full) begin
          r_ovf <= 1'b1;
        end
      end
    end

    assign w_head[q]      = r_mem[r_rd_ptr];
    assign w_count[q]     = r_count;
    assign w_full[q]      = r_full;
    assign w_ovf[q]       = r_ovf;
    assign w_non_empty[q] = (r_count != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 2'b00;
    w_load_en   = (r_state == ST_EMPTY) || bus.down_ready;
    // Tie-break favours the queue that did not win the previous load.
    w_grant     = (w_non_empty == 2'b11) ? ~r_last_grant : w_non_empty[1];
    if (w_load_en) begin
      if (w_non_empty != 2'b00) begin
        w_state_nxt    = ST_FULL;
        w_pop[w_grant] = 1'b1;
      end else begin
        w_state_nxt = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_down_data  <= '0;
      r_down_src   <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_pop != 2'b00) begin
      r_down_data  <= w_head[w_grant];
      r_down_src   <= w_grant;
      r_last_grant <= w_grant;
    end
  end

  assign bus.full_a     = w_full[0];
  assign bus.full_b     = w_full[1];
  assign bus.overflow_a = w_ovf[0];
  assign bus.overflow_b = w_ovf[1];
  assign bus.count_a    = w_count[0];
  assign bus.count_b    = w_count[1];
  assign bus.down_data  = r_down_data;
  assign bus.down_src   = r_down_src;
  assign bus.down_valid = (r_state == ST_FULL);

endmodule

`default_nettype wire

// File: tb/tb_dual_queue_rr_arbiter.sv
// ============================================================================
// Module      : tb_dual_queue_rr_arbiter
// Description : Scoreboard bench for dual_queue_rr_arbiter with a queue-based
//               reference model and randomized traffic.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dual_queue_rr_arbiter;

  localparam int D_WIDTH = 6;
  localparam int DEPTH   = 4;
  localparam int CW      = $clog2(DEPTH + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  dual_queue_rr_arbiter_if #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

  dual_queue_rr_arbiter #(.D_WIDTH(D_WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queue contents, output slot and arbitration history.
  logic [D_WIDTH-1:0] mq_a [$];
  logic [D_WIDTH-1:0] mq_b [$];
  logic [D_WIDTH:0]   exp_q [$];
  bit                 m_valid;
  bit                 m_last_b;
  bit                 m_ovf_a;
  bit                 m_ovf_b;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    int na;
    int nb;
    if (!rst_n) begin
      mq_a.delete();
      mq_b.delete();
      exp_q.delete();
      m_valid  = 1'b0;
      m_last_b = 1'b1;
      m_ovf_a  = 1'b0;
      m_ovf_b  = 1'b0;
    end else begin
      na = mq_a.size();
      nb = mq_b.size();
      if (!m_valid || bus.down_ready) begin
        if (na > 0 && (nb == 0 || m_last_b)) begin
          exp_q.push_back({1'b0, mq_a.pop_front()});
          m_valid  = 1'b1;
          m_last_b = 1'b0;
        end else if (nb > 0) begin
          exp_q.push_back({1'b1, mq_b.pop_front()});
          m_valid  = 1'b1;
          m_last_b = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (bus.push_a) begin
        if (na < DEPTH) mq_a.push_back(bus.up_data_a);
        else            m_ovf_a = 1'b1;
      end
      if (bus.push_b) begin
        if (nb < DEPTH) mq_b.push_back(bus.up_data_b);
        else            m_ovf_b = 1'b1;
      end
    end
  end

  // Monitor: status every cycle, payload whenever a handshake is pending.
  always @(negedge clk) begin : monitor
    logic [D_WIDTH:0] exp;
    if (rst_n) begin
      check("count_a", int'(bus.count_a), mq_a.size());
      check("count_b", int'(bus.count_b), mq_b.size());
      check("full_a", int'(bus.full_a), int'(mq_a.size() == DEPTH));
      check("full_b", int'(bus.full_b), int'(mq_b.size() == DEPTH));
      check("overflow_a", int'(bus.overflow_a), int'(m_ovf_a));
      check("overflow_b", int'(bus.overflow_b), int'(m_ovf_b));
      check("down_valid", int'(bus.down_valid), int'(m_valid));
      if (bus.down_valid && bus.down_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("down_src", int'(bus.down_src), int'(exp[D_WIDTH]));
          check("down_data", int'(bus.down_data), int'(exp[D_WIDTH-1:0]));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit a, input bit b,
                      input logic [D_WIDTH-1:0] da, input logic [D_WIDTH-1:0] db);
    bus.push_a    = a;
    bus.push_b    = b;
    bus.up_data_a = da;
    bus.up_data_b = db;
    tick();
    bus.push_a = 1'b0;
    bus.push_b = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, int'(bus.down_valid), 0);
    check({tag, "_data"}, int'(bus.down_data), 0);
    check({tag, "_src"}, int'(bus.down_src), 0);
    check({tag, "_count_a"}, int'(bus.count_a), 0);
    check({tag, "_count_b"}, int'(bus.count_b), 0);
    check({tag, "_full_a"}, int'(bus.full_a), 0);
    check({tag, "_ovf_a"}, int'(bus.overflow_a), 0);
    check({tag, "_ovf_b"}, int'(bus.overflow_b), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin : stimulus
    int thr_a;
    int thr_b;
    int thr_r;
    bus.push_a     = 1'b0;
    bus.push_b     = 1'b0;
    bus.up_data_a  = '0;
    bus.up_data_b  = '0;
    bus.down_ready = 1'b0;

    // Reset state, then single-entry latency.
    do_reset();
    check_all_zero("reset");
    push(1, 0, 6'h11, 6'h00);
    check("t1_count_a_e0", int'(bus.count_a), 1);
    check("t1_valid_e0", int'(bus.down_valid), 0);
    tick();
    check("t1_valid_e1", int'(bus.down_valid), 1);
    check("t1_data_e1", int'(bus.down_data), 'h11);
    check("t1_src_e1", int'(bus.down_src), 0);
    check("t1_count_a_e1", int'(bus.count_a), 0);
    bus.down_ready = 1'b1;
    tick();
    bus.down_ready = 1'b0;
    check("t1_drained", int'(bus.down_valid), 0);

    // Fill A past capacity with the consumer stalled.
    for (int i = 1; i <= 6; i++) push(1, 0, D_WIDTH'(i), 6'h00);
    check("t2_full_a", int'(bus.full_a), 1);
    check("t2_overflow_a", int'(bus.overflow_a), 1);
    check("t2_count_a", int'(bus.count_a), DEPTH);
    bus.down_ready = 1'b1;
    repeat (6) tick();
    bus.down_ready = 1'b0;
    check("t2_all_drained", exp_q.size(), 0);
    check("t2_overflow_sticky", int'(bus.overflow_a), 1);

    // Alternation from a fresh reset: A1, B1, A2, B2.
    do_reset();
    check("t3_overflow_cleared", int'(bus.overflow_a), 0);
    push(1, 1, 6'h21, 6'h31);
    push(1, 1, 6'h22, 6'h32);
    check("t3_first_src", int'(bus.down_src), 0);
    check("t3_first_data", int'(bus.down_data), 'h21);
    bus.down_ready = 1'b1;
    tick();
    check("t3_second_src", int'(bus.down_src), 1);
    check("t3_second_data", int'(bus.down_data), 'h31);
    repeat (4) tick();
    bus.down_ready = 1'b0;

    // Stall with valid held, then release.
    push(1, 0, 6'h2A, 6'h00);
    push(1, 0, 6'h2B, 6'h00);
    repeat (3) tick();
    check("t4_held_data", int'(bus.down_data), 'h2A);
    bus.down_ready = 1'b1;
    tick();
    check("t4_next_data", int'(bus.down_data), 'h2B);
    tick();
    bus.down_ready = 1'b0;

    // Simultaneous push and pop at count 2.
    push(1, 0, 6'h01, 6'h00);
    push(1, 0, 6'h02, 6'h00);
    push(1, 0, 6'h03, 6'h00);
    check("t5_count_before", int'(bus.count_a), 2);
    bus.down_ready = 1'b1;
    push(1, 0, 6'h04, 6'h00);
    bus.down_ready = 1'b0;
    check("t5_count_after", int'(bus.count_a), 2);
    check("t5_order", int'(bus.down_data), 'h02);
    bus.down_ready = 1'b1;
    repeat (5) tick();
    bus.down_ready = 1'b0;

    // Asynchronous reset mid-drain with both queues occupied.
    for (int i = 0; i < 3; i++) push(1, 1, D_WIDTH'(8 + i), D_WIDTH'(16 + i));
    push(1, 0, 6'h3F, 6'h00);
    push(1, 0, 6'h3E, 6'h00);
    bus.down_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    bus.down_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    push(0, 1, 6'h00, 6'h3C);
    tick();
    check("t6_b_valid", int'(bus.down_valid), 1);
    check("t6_b_src", int'(bus.down_src), 1);
    check("t6_b_data", int'(bus.down_data), 'h3C);
    bus.down_ready = 1'b1;
    tick();
    bus.down_ready = 1'b0;

    // Randomized traffic in segments of varying load and backpressure.
    for (int seg = 0; seg < 8; seg++) begin
      thr_a = $urandom_range(1, 9);
      thr_b = $urandom_range(1, 9);
      thr_r = $urandom_range(1, 9);
      for (int c = 0; c < 400; c++) begin
        bus.push_a     = ($urandom_range(0, 9) < thr_a);
        bus.push_b     = ($urandom_range(0, 9) < thr_b);
        bus.up_data_a  = D_WIDTH'($urandom);
        bus.up_data_b  = D_WIDTH'($urandom);
        bus.down_ready = ($urandom_range(0, 9) < thr_r);
        tick();
      end
      if (seg == 4) begin
        bus.push_a = 1'b0;
        bus.push_b = 1'b0;
        do_reset();
      end
    end

    bus.push_a     = 1'b0;
    bus.push_b     = 1'b0;
    bus.down_ready = 1'b1;
    repeat (4 * DEPTH + 4) tick();
    check("final_sb_empty", exp_q.size(), 0);
    check("final_valid", int'(bus.down_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
